// File: rtl/pe_conv_mac_ctrl_conv1_pkg.sv
// Shared types and sizing helpers for the conv1 MAC input-buffer sequencer.
package pe_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tap_flags_t;

  // Never returns 0 so that degenerate sizes still give a legal vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int taps_of(input int kernel_size);
    return kernel_size * kernel_size;
  endfunction

  function automatic int groups_of(input int channels, input int parallel);
    return channels / parallel;
  endfunction

endpackage

// File: rtl/pe_conv_mac_ctrl_conv1_if.sv
// Window handshake plus buffer/MAC strobes between the sequencer and its neighbours.
interface pe_conv_mac_ctrl_conv1_if #(
  parameter int pPIXEL_WIDTH = 4
);
  logic                    win_valid;
  logic                    win_ready;
  logic                    buf_en;
  logic [pPIXEL_WIDTH-1:0] buf_pixel;
  logic                    mac_clr;
  logic                    mac_acc;
  logic                    mac_last;
  logic                    done;
  logic                    busy;

  modport master (
    input  win_valid,
    output win_ready, buf_en, buf_pixel, mac_clr, mac_acc, mac_last, done, busy
  );

  modport slave (
    output win_valid,
    input  win_ready, buf_en, buf_pixel, mac_clr, mac_acc, mac_last, done, busy
  );
endinterface

// File: rtl/pe_conv_mac_ctrl_conv1_delay.sv
// Shift register that aligns the tap flags with the buffer's output latency.
module pe_conv_mac_ctrl_delay
  import pe_conv_pkg::*;
#(
  parameter int pDEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  tap_flags_t flags_in,
  output tap_flags_t flags_out
);

  tap_flags_t stage [pDEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < pDEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= flags_in;
      for (int i = 1; i < pDEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign flags_out = stage[pDEPTH-1];

endmodule

// File: rtl/pe_conv_mac_ctrl_conv1.sv
// conv1 MAC input-buffer sequencer: load a window group, scan its taps, drain the buffer latency.
//   state | meaning
//   IDLE  | ready for the next group, done pulses here after a window
//   LOAD  | one-cycle buffer load strobe
//   SCAN  | stepping buf_pixel through all taps
//   DRAIN | waiting out buffer latency after the final group
module pe_conv_mac_ctrl_conv1
  import pe_conv_pkg::*;
#(
  parameter int pKERNEL_SIZE    = 3,
  parameter int pINPUT_CHANNEL  = 1,
  parameter int pINPUT_PARALLEL = 1,
  parameter int pBUF_LATENCY    = 1,
  parameter int pPIXEL_WIDTH    = 4
) (
  input logic clk,
  input logic rst,
  pe_conv_mac_ctrl_conv1_if.master bus
);

  localparam int TAPS  = taps_of(pKERNEL_SIZE);
  localparam int G     = groups_of(pINPUT_CHANNEL, pINPUT_PARALLEL);
  localparam int TAP_W = clog2_min1(TAPS);
  localparam int GRP_W = clog2_min1(G);
  localparam int DRN_W = clog2_min1(pBUF_LATENCY);

  if (pINPUT_CHANNEL % pINPUT_PARALLEL != 0) begin : g_chk_groups
    $error("pINPUT_CHANNEL must be a multiple of pINPUT_PARALLEL");
  end
  if ((1 << pPIXEL_WIDTH) < TAPS) begin : g_chk_pixel
    $error("pPIXEL_WIDTH too narrow for pKERNEL_SIZE**2 taps");
  end
  if (pBUF_LATENCY < 1) begin : g_chk_latency
    $error("pBUF_LATENCY must be at least 1");
  end

  ctrl_state_e       state;
  ctrl_state_e       state_nxt;
  logic [TAP_W-1:0]  tap_cnt;
  logic [GRP_W-1:0]  grp_cnt;
  logic [DRN_W-1:0]  drn_cnt;
  logic              done_q;
  logic              rst_q;
  logic              tap_last;
  logic              grp_last;
  logic              drn_zero;
  logic              ready;
  tap_flags_t        flags_scan;
  tap_flags_t        flags_mac;

  assign tap_last = (tap_cnt == TAP_W'(TAPS - 1));
  assign grp_last = (grp_cnt == GRP_W'(G - 1));
  assign drn_zero = (drn_cnt == '0);
  // rst_q holds ready low for the cycle after any reset edge without a comb path from rst.
  assign ready    = (state == ST_IDLE) && !rst_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.win_valid && ready) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SCAN;
      ST_SCAN:  if (tap_last) state_nxt = grp_last ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (drn_zero) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt <= '0;
      grp_cnt <= '0;
      drn_cnt <= '0;
      done_q  <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      rst_q  <= 1'b0;
      done_q <= (state == ST_DRAIN) && drn_zero;
      case (state)
        ST_LOAD: tap_cnt <= '0;
        ST_SCAN: begin
          if (tap_last) begin
            tap_cnt <= '0;
            if (grp_last) drn_cnt <= DRN_W'(pBUF_LATENCY - 1);
            else          grp_cnt <= grp_cnt + 1'b1;
          end else begin
            tap_cnt <= tap_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drn_zero) grp_cnt <= '0;
          else          drn_cnt <= drn_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    flags_scan.vld   = (state == ST_SCAN);
    flags_scan.first = (state == ST_SCAN) && (tap_cnt == '0) && (grp_cnt == '0);
    flags_scan.last  = (state == ST_SCAN) && tap_last && grp_last;
  end

  pe_conv_mac_ctrl_delay #(
    .pDEPTH (pBUF_LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .flags_in  (flags_scan),
    .flags_out (flags_mac)
  );

  always_comb begin
    bus.win_ready = ready;
    bus.buf_en    = (state == ST_LOAD);
    bus.buf_pixel = (state == ST_SCAN) ? pPIXEL_WIDTH'(tap_cnt) : '0;
    bus.mac_acc   = flags_mac.vld;
    bus.mac_clr   = flags_mac.first;
    bus.mac_last  = flags_mac.last;
    bus.done      = done_q;
    bus.busy      = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_pe_conv_mac_ctrl_conv1.sv
// Bench for pe_conv_mac_ctrl_conv1: three configurations checked cycle by cycle against a timing scoreboard.
module tb_pe_conv_mac_ctrl_conv1;

  typedef logic [10:0] vec_t;

  localparam int B_DONE  = 0;
  localparam int B_LAST  = 1;
  localparam int B_ACC   = 2;
  localparam int B_CLR   = 3;
  localparam int B_PIX   = 4;
  localparam int B_EN    = 8;
  localparam int B_BUSY  = 9;
  localparam int B_READY = 10;

  localparam int TAPS = 9;
  localparam int CFG_G [3] = '{1, 2, 1};
  localparam int CFG_L [3] = '{1, 1, 3};

  logic clk;
  logic vld  [3];
  logic rsts [3];
  vec_t obs  [3];

  vec_t sb_q [3][$];
  int   grp      [3];
  bit   rst_prev [3];

  int n_checks;
  int n_fail;

  pe_conv_mac_ctrl_conv1_if #(.pPIXEL_WIDTH(4)) bus0 ();
  pe_conv_mac_ctrl_conv1_if #(.pPIXEL_WIDTH(4)) bus1 ();
  pe_conv_mac_ctrl_conv1_if #(.pPIXEL_WIDTH(4)) bus2 ();

  pe_conv_mac_ctrl_conv1 #(
    .pKERNEL_SIZE(3), .pINPUT_CHANNEL(1), .pINPUT_PARALLEL(1), .pBUF_LATENCY(1), .pPIXEL_WIDTH(4)
  ) dut0 (.clk(clk), .rst(rsts[0]), .bus(bus0));

  pe_conv_mac_ctrl_conv1 #(
    .pKERNEL_SIZE(3), .pINPUT_CHANNEL(2), .pINPUT_PARALLEL(1), .pBUF_LATENCY(1), .pPIXEL_WIDTH(4)
  ) dut1 (.clk(clk), .rst(rsts[1]), .bus(bus1));

  pe_conv_mac_ctrl_conv1 #(
    .pKERNEL_SIZE(3), .pINPUT_CHANNEL(1), .pINPUT_PARALLEL(1), .pBUF_LATENCY(3), .pPIXEL_WIDTH(4)
  ) dut2 (.clk(clk), .rst(rsts[2]), .bus(bus2));

  assign bus0.win_valid = vld[0];
  assign bus1.win_valid = vld[1];
  assign bus2.win_valid = vld[2];

  assign obs[0] = {bus0.win_ready, bus0.busy, bus0.buf_en, bus0.buf_pixel,
                   bus0.mac_clr, bus0.mac_acc, bus0.mac_last, bus0.done};
  assign obs[1] = {bus1.win_ready, bus1.busy, bus1.buf_en, bus1.buf_pixel,
                   bus1.mac_clr, bus1.mac_acc, bus1.mac_last, bus1.done};
  assign obs[2] = {bus2.win_ready, bus2.busy, bus2.buf_en, bus2.buf_pixel,
                   bus2.mac_clr, bus2.mac_acc, bus2.mac_last, bus2.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bits for cycle (now + off); queue front is the current cycle once popped.
  function automatic void put(input int d, input int off, input vec_t bits);
    while (sb_q[d].size() < off) sb_q[d].push_back('0);
    sb_q[d][off-1] = sb_q[d][off-1] | bits;
  endfunction

  function automatic void push_group(input int d);
    bit fin;
    int l;
    vec_t one;
    one = 11'd1;
    l   = CFG_L[d];
    fin = (grp[d] == CFG_G[d] - 1);
    for (int o = 1; o <= TAPS + 1 + (fin ? l : 0); o++) put(d, o, one << B_BUSY);
    put(d, 1, one << B_EN);
    for (int p = 0; p < TAPS; p++) begin
      put(d, 2 + p, vec_t'(p) << B_PIX);
      put(d, 2 + l + p, one << B_ACC);
    end
    if (grp[d] == 0) put(d, 2 + l, one << B_CLR);
    if (fin) begin
      put(d, TAPS + 1 + l, one << B_LAST);
      put(d, TAPS + 2 + l, one << B_DONE);
    end
    grp[d] = fin ? 0 : grp[d] + 1;
  endfunction

  function automatic vec_t sb_cycle(input int d, input bit v, input bit r);
    vec_t e;
    bit   ready;
    e = (sb_q[d].size() > 0) ? sb_q[d].pop_front() : vec_t'(0);
    ready = !e[B_BUSY] && !rst_prev[d];
    e[B_READY] = ready;
    if (r) begin
      sb_q[d].delete();
      grp[d] = 0;
    end else if (v && ready) begin
      push_group(d);
    end
    rst_prev[d] = r;
    return e;
  endfunction

  task automatic test_reset();
    vec_t e;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        vld[d]  = 1'b0;
        rsts[d] = (i < 2);
        e = sb_cycle(d, 1'b0, rsts[d]);
        n_checks++;
        if (obs[d] !== e) begin
          n_fail++;
          $display("FAIL reset dut%0d cycle %0d: got %h expected %h", d, i, obs[d], e);
        end
      end
    end
  endtask

  task automatic test_default();
    vec_t e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vld[0] = (i == 0);
      e = sb_cycle(0, vld[0], 1'b0);
      n_checks++;
      if (obs[0] !== e) begin
        n_fail++;
        $display("FAIL default cycle %0d: got %h expected %h", i, obs[0], e);
      end
    end
  endtask

  task automatic test_ignore_valid();
    vec_t e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vld[0] = (i <= 11);
      e = sb_cycle(0, vld[0], 1'b0);
      n_checks++;
      if (obs[0] !== e) begin
        n_fail++;
        $display("FAIL ignore_valid cycle %0d: got %h expected %h", i, obs[0], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t e;
    int   clr_seen;
    clr_seen = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      vld[1] = (i <= 22);
      e = sb_cycle(1, vld[1], 1'b0);
      if (obs[1][B_CLR] === 1'b1) clr_seen++;
      n_checks++;
      if (obs[1] !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs[1], e);
      end
    end
    n_checks++;
    if (clr_seen !== 1) begin
      n_fail++;
      $display("FAIL back_to_back clr_count: got %0d expected 1", clr_seen);
    end
  endtask

  task automatic test_latency3();
    vec_t e;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      vld[2] = (i == 0);
      e = sb_cycle(2, vld[2], 1'b0);
      n_checks++;
      if (obs[2] !== e) begin
        n_fail++;
        $display("FAIL latency3 cycle %0d: got %h expected %h", i, obs[2], e);
      end
    end
  endtask

  task automatic test_abort();
    vec_t e;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      vld[0]  = (i == 0) || (i == 10);
      rsts[0] = (i == 6);
      e = sb_cycle(0, vld[0], rsts[0]);
      n_checks++;
      if (obs[0] !== e) begin
        n_fail++;
        $display("FAIL abort cycle %0d: got %h expected %h", i, obs[0], e);
      end
    end
  endtask

  task automatic test_idle_wait();
    vec_t e;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      vld[1] = (i == 0) || (i == 25) || (i == 57);
      e = sb_cycle(1, vld[1], 1'b0);
      n_checks++;
      if (obs[1] !== e) begin
        n_fail++;
        $display("FAIL idle_wait cycle %0d: got %h expected %h", i, obs[1], e);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 3; d++) begin
      vld[d]      = 1'b0;
      rsts[d]     = 1'b1;
      rst_prev[d] = 1'b1;
      grp[d]      = 0;
    end
    repeat (3) @(posedge clk);
    test_reset();
    test_default();
    test_ignore_valid();
    test_back_to_back();
    test_latency3();
    test_abort();
    test_idle_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_conv_mac_ctrl_conv1.md
# pe_conv_mac_ctrl_conv1

Sequencer for the conv1 MAC input buffer. Accepts one packed kernel window per input-channel group from upstream via a valid/ready handshake. Pulses the buffer load enable, then steps the buffer pixel select through all pKERNEL_SIZE² taps. Emits MAC clear/accumulate/last strobes aligned to the buffer's output latency, plus a done pulse per output window. Sits between the line-buffer/window generator and pe_conv_mac_buffer_in_conv1 plus its MAC.

## Interface
- pKERNEL_SIZE, 3, kernel side; taps TAPS = pKERNEL_SIZE²
- pINPUT_CHANNEL, 1, input channels per window
- pINPUT_PARALLEL, 1, channels carried per buffer load; groups G = pINPUT_CHANNEL/pINPUT_PARALLEL
- pBUF_LATENCY, 1, cycles from buf_pixel change to matching buffer data_out (L, ≥1)
- pPIXEL_WIDTH, 4, width of pixel select (must satisfy 2^pPIXEL_WIDTH ≥ TAPS)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- win_valid  in  1  upstream has a window group on the buffer's data_in
- win_ready  out  1  controller can accept a group
- buf_en  out  1  one-cycle load strobe to buffer en
- buf_pixel  out  pPIXEL_WIDTH  tap select to buffer pixel
- mac_clr  out  1  first accumulate of a window; MAC clears then accumulates
- mac_acc  out  1  buffer data_out is a valid tap this cycle
- mac_last  out  1  final tap of final group
- done  out  1  one-cycle pulse, window complete
- busy  out  1  high in any state other than IDLE

## Operation
- Elaboration error if pINPUT_CHANNEL % pINPUT_PARALLEL ≠ 0, if 2^pPIXEL_WIDTH < TAPS, or if pBUF_LATENCY < 1.
- Counters: tap_cnt is $clog2(TAPS) bits, 0..TAPS-1. grp_cnt is max(1,$clog2(G)) bits, 0..G-1. Both wrap to 0 only under control of the FSM; no other arithmetic.
- FSM states: IDLE, LOAD, SCAN, DRAIN.
- IDLE: win_ready=1. On win_valid&&win_ready, go to LOAD.
- LOAD: buf_en=1 for exactly one cycle; tap_cnt←0; go to SCAN.
- SCAN: buf_pixel=tap_cnt, increments every cycle.
  - At tap_cnt=TAPS-1 with grp_cnt<G-1: grp_cnt++ and go to IDLE.
  - At tap_cnt=TAPS-1 with grp_cnt=G-1: go to DRAIN.
- DRAIN: lasts exactly L cycles, then go to IDLE with done=1 in the first IDLE cycle; grp_cnt←0.
- buf_pixel is 0 outside SCAN.
- Internal tap flags are generated in SCAN:
  - vld = 1 on every SCAN cycle
  - first = (tap_cnt==0 && grp_cnt==0)
  - last = (tap_cnt==TAPS-1 && grp_cnt==G-1)
- The tap flags pass through an L-stage delay line to become mac_acc, mac_clr and mac_last.
- win_valid is ignored outside IDLE.
- Between groups the controller waits in IDLE indefinitely. No timeout.
- Reset values: win_ready=0 while rst=1, then 1; all other outputs 0.
- Reset mid-operation: state←IDLE and counters←0 on the next edge. The delay line is flushed, so no mac_acc, mac_last or done is emitted for the aborted window.

## Timing
- Cycle 0 is the cycle in which win_valid&&win_ready is sampled.
- buf_en is high in cycle 1.
- buf_pixel = 0..TAPS-1 in cycles 2..TAPS+1.
- mac_acc is high in cycles 2+L..TAPS+1+L. mac_clr is in cycle 2+L (group 0 only). mac_last is in cycle TAPS+1+L (last group only).
- Non-final group: win_ready is high again in cycle TAPS+2, so back-to-back groups cost TAPS+2 cycles each.
- Final group: DRAIN covers cycles TAPS+2..TAPS+1+L. done and win_ready are high in cycle TAPS+2+L.
- Window throughput: G·(TAPS+2)+L cycles.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.

## Structure
- Package pe_conv_pkg holds:
  - the FSM state enum
  - localparam/function for TAPS and G
  - the common clog2 width helper
- Sub-module pe_conv_mac_ctrl_delay holds the pBUF_LATENCY-stage shift register carrying {vld, first, last}, with synchronous clear on rst.

## Test plan
- Defaults (K=3, CH=1, PAR=1, L=1), win_valid held high from reset release, handshake in cycle 0 → buf_en in cycle 1; buf_pixel 0..8 in cycles 2..10; mac_acc in cycles 3..11; mac_clr in cycle 3; mac_last in cycle 11; done and win_ready in cycle 12.
- CH=2, PAR=1, L=1, back-to-back groups → second buf_en in cycle 12; buf_pixel 0..8 in cycles 13..21; mac_clr exactly once (cycle 3); mac_last in cycle 22; done in cycle 23.
- L=3, defaults otherwise → mac_acc in cycles 5..13; DRAIN 3 cycles; done in cycle 14.
- Pulse win_valid during cycles 1..11 (not IDLE) → ignored: no second buf_en and no counter disturbance.
- rst asserted in cycle 6 of a window → from cycle 7 all outputs 0 except win_ready=1 after rst drops; no done is ever emitted for that window; the next window runs the normal cycle-0..12 sequence.
- After the second group completes, hold win_valid low for 20 cycles → the FSM waits in IDLE with busy=0; no spurious strobes; the next handshake restarts at group 0 with mac_clr.
